// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and the message ROM for the UART self-test.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int MSG_LEN   = 12;

    // TX states name what is currently driven on the line
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_DATA  = 2'd1;
    localparam logic [1:0] RX_STOP  = 2'd2;

    localparam logic [1:0] SEQ_WAIT = 2'd0;
    localparam logic [1:0] SEQ_SEND = 2'd1;
    localparam logic [1:0] SEQ_GAP  = 2'd2;

    // "hello world\n"
    function automatic logic [7:0] msg_char(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h68;
            4'd1:    c = 8'h65;
            4'd2:    c = 8'h6C;
            4'd3:    c = 8'h6C;
            4'd4:    c = 8'h6F;
            4'd5:    c = 8'h20;
            4'd6:    c = 8'h77;
            4'd7:    c = 8'h6F;
            4'd8:    c = 8'h72;
            4'd9:    c = 8'h6C;
            4'd10:   c = 8'h64;
            4'd11:   c = 8'h0A;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 receiver sampling once per tick; valid_o pulses on a good stop bit.
module uart_rx_8n1
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       ser_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    logic [1:0] state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_q, bit_d;

    // Combinational so the consumer can capture on the stop-tick edge itself
    assign valid_o = tick_i && (state_q == RX_STOP) && ser_i;
    assign data_o  = shreg_q;

    // Next-state: start detect, LSB-first shift, stop check
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        if (tick_i) begin
            case (state_q)
                RX_IDLE: begin
                    if (!ser_i) begin
                        state_d = RX_DATA;
                        bit_d   = 3'd0;
                    end
                end
                RX_DATA: begin
                    shreg_d = {ser_i, shreg_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
                    else                            bit_d   = bit_q + 3'd1;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            shreg_q <= 8'h00;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 transmitter, one bit per tick, registered line output.
module uart_tx_8n1
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       ser_o
);

    logic [1:0] state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_q, bit_d;
    logic       ser_q, ser_d;

    // Accepting on the stop tick lets frames run back-to-back
    assign ready_o = (state_q == TX_IDLE) || (state_q == TX_STOP);
    assign ser_o   = ser_q;

    // Next-state: every transition happens on a tick only
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        ser_d   = ser_q;
        if (tick_i) begin
            case (state_q)
                TX_IDLE, TX_STOP: begin
                    if (valid_i) begin
                        state_d = TX_START;
                        shreg_d = data_i;
                        ser_d   = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        ser_d   = 1'b1;
                    end
                end
                TX_START: begin
                    ser_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        ser_d   = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        ser_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end
    end

    // State registers; line idles high in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            shreg_q <= 8'h00;
            bit_q   <= 3'd0;
            ser_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            ser_q   <= ser_d;
        end
    end

endmodule

// File: rtl/uart_hello_top.sv
// UART self-test: message sequencer -> 8N1 TX -> internal loopback -> 8N1 RX -> leds.
module uart_hello_top
    import uart_pkg::*;
#(
    parameter int START_IDLE_BITS = 4,
    parameter int MSG_GAP_BITS    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_in,
    output logic       ser_tx,
    output logic [7:0] leds
);

    localparam int MAX_WAIT = (START_IDLE_BITS > MSG_GAP_BITS) ? START_IDLE_BITS : MSG_GAP_BITS;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    logic             baud_q;
    logic             tick;
    logic [1:0]       seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       leds_q;
    logic             tx_valid, tx_ready;
    logic             rx_ser;
    logic [7:0]       rx_data;
    logic             rx_valid;

    // baud_in is only ever sampled; its rising edge becomes a one-clk tick
    assign tick = baud_in & ~baud_q;

    assign tx_valid = (seq_q == SEQ_SEND);
    assign rx_ser   = ser_tx;
    assign leds     = leds_q;

    // Sequencer next-state: idle lead-in, back-to-back bytes, inter-message gap
    always_comb begin
        seq_d = seq_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (tick && tx_ready) begin
            case (seq_q)
                SEQ_WAIT: begin
                    if (cnt_q == CNT_W'(START_IDLE_BITS - 1)) begin
                        seq_d = SEQ_SEND;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SEQ_SEND: begin
                    if (idx_q == 4'(MSG_LEN - 1)) begin
                        idx_d = 4'd0;
                        seq_d = SEQ_GAP;
                        cnt_d = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                SEQ_GAP: begin
                    // Ticks are only counted once TX is back to stop/idle
                    if (cnt_q == CNT_W'(MSG_GAP_BITS - 1)) begin
                        seq_d = SEQ_SEND;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: seq_d = SEQ_WAIT;
            endcase
        end
    end

    // Tick edge register, sequencer state and last-good-byte display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= 1'b0;
            seq_q  <= SEQ_WAIT;
            cnt_q  <= '0;
            idx_q  <= 4'd0;
            leds_q <= 8'h00;
        end else begin
            baud_q <= baud_in;
            seq_q  <= seq_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            if (rx_valid) leds_q <= rx_data;
        end
    end

    uart_tx_8n1 u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick),
        .data_i  (msg_char(idx_q)),
        .valid_i (tx_valid),
        .ready_o (tx_ready),
        .ser_o   (ser_tx)
    );

    uart_rx_8n1 u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick),
        .ser_i   (rx_ser),
        .data_o  (rx_data),
        .valid_o (rx_valid)
    );

endmodule

// File: tb/tb_uart_hello_top.sv
// Directed bench for uart_hello_top: frames checked tick by tick on ser_tx.
module tb_uart_hello_top;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       baud_in = 1'b0;
    logic       ser_tx;
    logic [7:0] leds;

    int n_cmp = 0;
    int n_err = 0;

    logic       baud_run  = 1'b1;
    logic [2:0] bcnt      = 3'd0;
    logic       baud_prev = 1'b0;
    logic       tb_tick   = 1'b0;

    logic [7:0] msg [12] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0A};

    uart_hello_top #(.START_IDLE_BITS(4), .MSG_GAP_BITS(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .baud_in (baud_in),
        .ser_tx  (ser_tx),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    // baud_in = clk/8; when paused it runs on until low, then holds
    always @(negedge clk) begin
        if (baud_run || baud_in) begin
            bcnt    = bcnt + 3'd1;
            baud_in = bcnt[2];
        end
    end

    // Independent tick reference from the bench's own view of baud_in
    always @(posedge clk) begin
        if (!rst_n) begin
            tb_tick   = 1'b0;
            baud_prev = 1'b0;
        end else begin
            tb_tick   = baud_in & ~baud_prev;
            baud_prev = baud_in;
        end
    end

    task automatic next_tick();
        bit got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(posedge clk);
            #1;
            got = tb_tick;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL tick_timeout: no tick within 64 clks");
        end
    endtask

    // One 10-tick frame; leds_exp is the value expected from the first tick on
    task automatic frame(input logic [7:0] b, input logic [7:0] leds_exp,
                         input int pause_after, input bit force_stop);
        logic [9:0] exp_v;
        logic [9:0] got_v;
        exp_v = {1'b1, b, 1'b0};
        got_v = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 && force_stop) force dut.rx_ser = 1'b0;
            next_tick();
            got_v[i] = ser_tx;
            if (i == 0) begin
                if (force_stop) release dut.rx_ser;
                n_cmp++;
                if (leds !== leds_exp) begin
                    n_err++;
                    $display("FAIL leds_at_start(%h): got %h want %h", b, leds, leds_exp);
                end
            end
            if (i + 1 == pause_after) begin
                baud_run = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                n_cmp++;
                if (ser_tx !== exp_v[i]) begin
                    n_err++;
                    $display("FAIL frozen_ser: got %b want %b", ser_tx, exp_v[i]);
                end
                n_cmp++;
                if (leds !== leds_exp) begin
                    n_err++;
                    $display("FAIL frozen_leds: got %h want %h", leds, leds_exp);
                end
                baud_run = 1'b1;
            end
        end
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL frame(%h): got %b want %b", b, got_v, exp_v);
        end
    endtask

    task automatic idle_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            next_tick();
            n_cmp++;
            if (ser_tx !== 1'b1) begin
                n_err++;
                $display("FAIL %s_idle%0d: got %b want 1", tag, i, ser_tx);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (ser_tx !== 1'b1) begin n_err++; $display("FAIL reset_ser: got %b want 1", ser_tx); end
        n_cmp++;
        if (leds !== 8'h00) begin n_err++; $display("FAIL reset_leds: got %h want 00", leds); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_ticks(4, "startup");
    endtask

    task automatic test_first_frame();
        frame(8'h68, 8'h00, 0, 1'b0);
    endtask

    task automatic test_message();
        for (int i = 1; i < 12; i++) frame(msg[i], msg[i-1], 0, 1'b0);
        next_tick();
        n_cmp++;
        if (ser_tx !== 1'b1 || leds !== 8'h0A) begin
            n_err++;
            $display("FAIL gap_first: got ser=%b leds=%h want ser=1 leds=0a", ser_tx, leds);
        end
        idle_ticks(1, "gap");
        frame(8'h68, 8'h0A, 0, 1'b0);
    endtask

    task automatic test_freeze();
        frame(8'h65, 8'h68, 4, 1'b0);
    endtask

    task automatic test_reset_mid();
        // 0x6C frame: start, b0=0, b1=0 -> line is low after 3 ticks
        for (int i = 0; i < 3; i++) next_tick();
        n_cmp++;
        if (ser_tx !== 1'b0 || leds !== 8'h65) begin
            n_err++;
            $display("FAIL pre_reset: got ser=%b leds=%h want ser=0 leds=65", ser_tx, leds);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ser_tx !== 1'b1) begin n_err++; $display("FAIL async_ser: got %b want 1", ser_tx); end
        n_cmp++;
        if (leds !== 8'h00) begin n_err++; $display("FAIL async_leds: got %h want 00", leds); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_ticks(4, "rerun");
        frame(8'h68, 8'h00, 0, 1'b0);
    endtask

    task automatic test_rx_stop_error();
        frame(8'h65, 8'h68, 0, 1'b0);
        frame(8'h6C, 8'h68, 0, 1'b1);
        frame(8'h6C, 8'h6C, 0, 1'b0);
        next_tick();
        n_cmp++;
        if (leds !== 8'h6C) begin n_err++; $display("FAIL rx_recover: got %h want 6c", leds); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_message();
        test_freeze();
        test_reset_mid();
        test_rx_stop_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
